// File: rtl/fifo_stream_reader.sv
// Read-side controller for the SRAM circular FIFO: issues reads on credit and re-times the words onto a valid/ready stream.
// Optional delivered-word counter on rd_count when FIFO_RD_CNT_EN is defined.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

  logic [1:0]            cnt_r;
  logic                  inflight_r;
  logic [DATA_WIDTH-1:0] buf0_r;
  logic [DATA_WIDTH-1:0] buf1_r;
  logic                  m_valid_r;

  logic                  pop_s;
  logic [2:0]            credit_s;
  logic [1:0]            cnt_after_pop_s;
  logic [1:0]            cnt_next_s;
  logic [DATA_WIDTH-1:0] buf0_next_s;
  logic [DATA_WIDTH-1:0] buf1_next_s;

  assign pop_s    = m_valid_r & m_ready;
  // Slots still committed after this cycle's pop; a read is issued only while a slot is free.
  assign credit_s = {1'b0, cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign fifo_rd  = rstn & i_en & ~fifo_empty & (credit_s < 3'd2);

  assign cnt_after_pop_s = cnt_r - {1'b0, pop_s};
  assign cnt_next_s      = cnt_after_pop_s + {1'b0, inflight_r};

  // Buffer next state: shift on pop, then land the returning word in the first free slot.
  always_comb begin
    buf0_next_s = buf0_r;
    buf1_next_s = buf1_r;
    if (pop_s) begin
      buf0_next_s = buf1_r;
    end else begin
      buf0_next_s = buf0_r;
    end
    if (inflight_r) begin
      if (cnt_after_pop_s == 2'd0) begin
        buf0_next_s = fifo_data;
      end else begin
        buf1_next_s = fifo_data;
      end
    end else begin
      buf1_next_s = buf1_r;
    end
  end

  // Buffer, occupancy and in-flight tracking registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r      <= 2'd0;
      inflight_r <= 1'b0;
      buf0_r     <= {DATA_WIDTH{1'b0}};
      buf1_r     <= {DATA_WIDTH{1'b0}};
      m_valid_r  <= 1'b0;
    end else begin
      cnt_r      <= cnt_next_s;
      inflight_r <= fifo_rd;
      buf0_r     <= buf0_next_s;
      buf1_r     <= buf1_next_s;
      m_valid_r  <= (cnt_next_s != 2'd0);
    end
  end

  assign m_valid = m_valid_r;
  assign m_data  = buf0_r;

`ifdef FIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] rd_count_r;

  // Delivered-word counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_count_r <= {CNT_WIDTH{1'b0}};
    end else if (pop_s) begin
      rd_count_r <= rd_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rd_count_r <= rd_count_r;
    end
  end

  assign rd_count = rd_count_r;
`else
  logic unused_cnt_width_s;
  assign unused_cnt_width_s = (CNT_WIDTH > 0);
`endif

endmodule
